tc_timer: RTL

//   Memory-mapped timer/counter slave on the processor bridge's peripheral bus.
//   Two instances (TC0 at 0x7F00, TC1 at 0x7F10) receive the bridge's address, write data
//   and write enable, return read data, and raise an interrupt request on countdown expiry.
//   The bridge decodes the base address; this block decodes only the word offset Addr[3:2].

---
 rtl/tc_timer_if.sv | 12 +
 rtl/tc_timer.sv | 102 ++++++++++
 2 files changed

// File: rtl/tc_timer_if.sv
// Peripheral-bus bundle between the processor bridge and one timer/counter slave.
// The bridge (master) drives the address, write strobe and data; the timer returns read data and the interrupt request.
interface tc_timer_if;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   modport master (output Addr, WE, Din, input Dout, IRQ);
   modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/tc_timer.sv
// Memory-mapped countdown timer: after EN is written, COUNT loads PRESET two edges later and irq_flag rises PRESET+2 edges after the write; reads are combinational.
// Defining TC_IRQ_STATUS_EN turns offset 3 into a STATUS register (bit0 = irq_flag, write 1 to clear); without it, offset 3 reads 0.
module tc_timer #(
   parameter int               CNT_W      = 32,
   parameter logic [CNT_W-1:0] PRESET_RST = '0
) (
   input  logic        clk,
   input  logic        reset,
   tc_timer_if.slave   bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_t;

   state_t           state, state_nxt;
   logic [3:0]       ctrl;
   logic [CNT_W-1:0] preset, count;
   logic             irq_flag;

   logic [1:0] off;
   logic       en, auto_rl, im;
   logic       wr_ctrl, wr_preset, wr_stat_clr, cpu_clr, en_after_wr;
   logic       load_cnt, dec_cnt, expire, int_en_clr, int_flag_clr;
   logic       unused_addr;

   assign off     = bus.Addr[3:2];
   assign en      = ctrl[0];
   assign auto_rl = (ctrl[2:1] == 2'b01);
   assign im      = ctrl[3];

   assign wr_ctrl   = bus.WE && (off == 2'd0);
   assign wr_preset = bus.WE && (off == 2'd1);
`ifdef TC_IRQ_STATUS_EN
   assign wr_stat_clr = bus.WE && (off == 2'd3) && bus.Din[0];
`else
   assign wr_stat_clr = 1'b0;
`endif
   assign cpu_clr     = wr_ctrl || wr_preset || wr_stat_clr;
   // The enable the CPU leaves behind decides whether its clear beats a same-edge expiry.
   assign en_after_wr = wr_ctrl ? bus.Din[0] : en;

   assign unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = LOAD;
         LOAD:    state_nxt = CNT;
         CNT:     if (!en) state_nxt = IDLE;
                  else if (count <= CNT_W'(1)) state_nxt = INT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_cnt     = (state == LOAD);
      dec_cnt      = (state == CNT) && en && (count > CNT_W'(1));
      expire       = (state == CNT) && en && (count <= CNT_W'(1));
      int_en_clr   = (state == INT) && !auto_rl;
      int_flag_clr = (state == INT) && auto_rl;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl     <= 4'd0;
         preset   <= PRESET_RST;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         if (wr_ctrl)         ctrl    <= bus.Din[3:0];
         else if (int_en_clr) ctrl[0] <= 1'b0;

         if (wr_preset) preset <= CNT_W'(bus.Din);

         if (load_cnt)     count <= preset;
         else if (expire)  count <= '0;
         else if (dec_cnt) count <= count - CNT_W'(1);

         if (expire && !(cpu_clr && !en_after_wr)) irq_flag <= 1'b1;
         else if (cpu_clr || int_flag_clr)          irq_flag <= 1'b0;
      end
   end

   always_comb begin
      bus.Dout = 32'd0;
      case (off)
         2'd0:    bus.Dout = {28'd0, ctrl};
         2'd1:    bus.Dout = 32'(preset);
         2'd2:    bus.Dout = 32'(count);
`ifdef TC_IRQ_STATUS_EN
         default: bus.Dout = {31'd0, irq_flag};
`else
         default: bus.Dout = 32'd0;
`endif
      endcase
   end

   assign bus.IRQ = im && irq_flag;
endmodule
